// File: rtl/fifo_serial_tx.sv
// Serial transmitter that drains a FIFO read port one word at a time and sends
// each word as an async frame: start, data LSB first, optional even parity, stop.
module fifo_serial_tx #(
    parameter int WIDTH     = 16,
    parameter int BAUD_DIV  = 4,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic             fifo_read,
    output logic             tx_serial,
    output logic             busy,
    output logic             frame_done
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);
    localparam logic          PAR_ON    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    baud_q, baud_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             tx_q, tx_d;
    logic             read_q, read_d;

    logic             baud_last;
    logic [WIDTH-1:0] shift_nxt;

    assign baud_last = (baud_q == BAUD_LAST);
    assign shift_nxt = shift_q >> 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            read_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            read_q   <= read_d;
        end
    end

    // tx_d always carries the level of the state being entered, so the line
    // register changes exactly on bit boundaries.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        read_d   = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                if (enable && !fifo_empty) begin
                    read_d  = 1'b1;
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d  = fifo_data_out;
                parity_d = ^fifo_data_out;
                baud_d   = '0;
                tx_d     = 1'b0;
                state_d  = START;
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        tx_d    = PAR_ON ? parity_q : 1'b1;
                        state_d = PAR_ON ? PARITY : STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_nxt;
                        tx_d    = shift_nxt[0];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign fifo_read  = read_q;
    assign tx_serial  = tx_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == STOP) && baud_last;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: behavioural FIFO on the read port, a scoreboard of
// written words, and a line decoder that rebuilds each frame from the serial output.
module tb_fifo_serial_tx;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic [15:0] fifo_data_out;
    logic        fifo_read;
    logic        tx_serial;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_count = 0;
    int pop_cyc = 0;
    int read_wide = 0;
    logic read_prev;

    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] word;
        logic        par;
        logic [3:0]  stop;
        int          gap;
        int          done_idx;
        int          done_cnt;
        int          busy_low;
        int          unstable;
        int          start_cyc;
        bit          timed_out;
        bit          aborted;
        logic        tx_at_rst;
        logic        busy_at_rst;
    } frame_t;

    fifo_serial_tx #(.WIDTH(16), .BAUD_DIV(4), .PARITY_EN(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_data_out(fifo_data_out),
        .fifo_read    (fifo_read),
        .tx_serial    (tx_serial),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // FIFO model: a pop seen during the strobe cycle presents data for the next cycle.
    initial begin
        fifo_empty    = 1'b1;
        fifo_data_out = 16'h0000;
        read_prev     = 1'b0;
        forever begin
            @(negedge clk);
            if (fifo_read === 1'b1) begin
                if (read_prev === 1'b1) read_wide++;
                pop_count++;
                pop_cyc = cyc;
                if (fifo_q.size() > 0) fifo_data_out = fifo_q.pop_front();
            end
            read_prev  = fifo_read;
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic push_word(input logic [15:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // Decodes one frame from the line; optionally drops enable or asserts reset at a sample index.
    task automatic recv_frame(input int timeout, input int drop_en_idx, input int rst_idx,
                              output frame_t f);
        logic [75:0] s;
        f.word = '0; f.par = 1'b0; f.stop = '0; f.gap = 0; f.done_idx = -1;
        f.done_cnt = 0; f.busy_low = 0; f.unstable = 0; f.start_cyc = 0;
        f.timed_out = 1'b0; f.aborted = 1'b0; f.tx_at_rst = 1'bx; f.busy_at_rst = 1'bx;
        s = '0;
        @(negedge clk);
        while (tx_serial !== 1'b0) begin
            if (f.gap >= timeout) begin
                f.timed_out = 1'b1;
                return;
            end
            f.gap++;
            @(negedge clk);
        end
        f.start_cyc = cyc;
        for (int i = 0; i < 76; i++) begin
            if (i > 0) @(negedge clk);
            if (i == rst_idx) begin
                rst = 1'b0;
                #1;
                f.tx_at_rst   = tx_serial;
                f.busy_at_rst = busy;
                f.aborted     = 1'b1;
                return;
            end
            if (i == drop_en_idx) enable = 1'b0;
            s[i] = tx_serial;
            if (frame_done === 1'b1) begin
                f.done_cnt++;
                f.done_idx = i;
            end
            if (busy !== 1'b1) f.busy_low++;
        end
        for (int b = 0; b < 19; b++)
            for (int k = 1; k < 4; k++)
                if (s[4*b+k] !== s[4*b]) f.unstable++;
        if (s[0] !== 1'b0) f.unstable++;
        for (int i = 0; i < 16; i++) f.word[i] = s[4 + 4*i];
        f.par  = s[68];
        f.stop = s[75:72];
    endtask

    task automatic test_reset;
        logic [3:0] obs;
        rst    = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {tx_serial, fifo_read, busy, frame_done};
            checks++;
            if (obs !== 4'b1000) begin
                errors++;
                $display("FAIL reset_during cycle %0d: {tx,rd,busy,done}=%b required 1000", i, obs);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        obs = {tx_serial, fifo_read, busy, frame_done};
        checks++;
        if (obs !== 4'b1000) begin
            errors++;
            $display("FAIL reset_after: {tx,rd,busy,done}=%b required 1000", obs);
        end
        $display("test_reset: outputs checked during and after reset");
    endtask

    task automatic test_single;
        frame_t f;
        logic [15:0] exp;
        int p0;
        p0 = pop_count;
        push_word(16'h18E9);
        enable = 1'b1;
        recv_frame(50, -1, -1, f);
        exp = exp_q.pop_front();
        checks++;
        if (f.timed_out) begin errors++; $display("FAIL single_timeout: no start bit within 50 clocks, required frame"); end
        checks++;
        if (f.word !== exp) begin errors++; $display("FAIL single_word: got %h required %h", f.word, exp); end
        checks++;
        if (f.par !== ^exp) begin errors++; $display("FAIL single_parity: got %b required %b", f.par, ^exp); end
        checks++;
        if (f.stop !== 4'hF) begin errors++; $display("FAIL single_stop: got %b required 1111", f.stop); end
        checks++;
        if (f.unstable != 0) begin errors++; $display("FAIL single_bitwidth: %0d unstable samples required 0", f.unstable); end
        checks++;
        if (f.done_cnt != 1 || f.done_idx != 75) begin
            errors++;
            $display("FAIL single_frame_done: count %0d at clock %0d required 1 at 75", f.done_cnt, f.done_idx);
        end
        checks++;
        if (f.busy_low != 0) begin errors++; $display("FAIL single_busy: low %0d clocks in frame required 0", f.busy_low); end
        checks++;
        if (pop_count - p0 != 1 || read_wide != 0) begin
            errors++;
            $display("FAIL single_read_pulse: pops %0d wide %0d required 1 and 0", pop_count - p0, read_wide);
        end
        checks++;
        if (f.start_cyc - pop_cyc != 2) begin
            errors++;
            $display("FAIL single_latency: pop to start %0d required 2", f.start_cyc - pop_cyc);
        end
        @(negedge clk);
        checks++;
        if ({tx_serial, busy, frame_done} !== 3'b100) begin
            errors++;
            $display("FAIL single_idle: {tx,busy,done}=%b required 100", {tx_serial, busy, frame_done});
        end
        $display("test_single: word %h parity %b done@%0d", f.word, f.par, f.done_idx);
    endtask

    task automatic test_burst;
        frame_t f;
        logic [15:0] exp;
        int p0;
        p0 = pop_count;
        push_word(16'h18E9);
        push_word(16'h0000);
        push_word(16'hA9BA);
        enable = 1'b1;
        for (int n = 0; n < 3; n++) begin
            recv_frame(200, -1, -1, f);
            exp = exp_q.pop_front();
            checks++;
            if (f.word !== exp || f.timed_out) begin
                errors++;
                $display("FAIL burst_word%0d: got %h timeout %0d required %h", n, f.word, f.timed_out, exp);
            end
            checks++;
            if (f.par !== ^exp) begin errors++; $display("FAIL burst_parity%0d: got %b required %b", n, f.par, ^exp); end
            checks++;
            if (f.gap < 1 || f.unstable != 0 || f.done_cnt != 1 || f.stop !== 4'hF) begin
                errors++;
                $display("FAIL burst_frame%0d: gap %0d unstable %0d done %0d stop %b required >=1,0,1,1111",
                         n, f.gap, f.unstable, f.done_cnt, f.stop);
            end
            $display("test_burst: frame %0d word %h parity %b gap %0d", n, f.word, f.par, f.gap);
        end
        checks++;
        if (pop_count - p0 != 3 || read_wide != 0) begin
            errors++;
            $display("FAIL burst_pops: pops %0d wide %0d required 3 and 0", pop_count - p0, read_wide);
        end
    endtask

    task automatic test_empty;
        int viol;
        int p0;
        viol = 0;
        p0 = pop_count;
        enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fifo_read !== 1'b0 || tx_serial !== 1'b1 || busy !== 1'b0) viol++;
        end
        checks++;
        if (viol != 0 || pop_count != p0) begin
            errors++;
            $display("FAIL empty_idle: %0d bad cycles %0d pops required 0 and 0", viol, pop_count - p0);
        end
        $display("test_empty: 200 clocks with empty FIFO, %0d bad cycles", viol);
    endtask

    task automatic test_enable_drop;
        frame_t f;
        logic [15:0] exp;
        int p0;
        int viol;
        p0 = pop_count;
        viol = 0;
        push_word(16'h5A3C);
        push_word(16'hC001);
        enable = 1'b1;
        recv_frame(50, 20, -1, f);
        exp = exp_q.pop_front();
        checks++;
        if (f.word !== exp || f.done_cnt != 1 || f.stop !== 4'hF || f.par !== ^exp) begin
            errors++;
            $display("FAIL drop_frame1: word %h done %0d stop %b par %b required %h,1,1111,%b",
                     f.word, f.done_cnt, f.stop, f.par, exp, ^exp);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_read !== 1'b0 || tx_serial !== 1'b1 || busy !== 1'b0) viol++;
        end
        checks++;
        if (viol != 0 || pop_count - p0 != 1) begin
            errors++;
            $display("FAIL drop_hold: %0d bad cycles %0d pops required 0 and 1", viol, pop_count - p0);
        end
        enable = 1'b1;
        recv_frame(50, -1, -1, f);
        exp = exp_q.pop_front();
        checks++;
        if (f.word !== exp || f.timed_out || pop_count - p0 != 2) begin
            errors++;
            $display("FAIL drop_resume: word %h timeout %0d pops %0d required %h,0,2",
                     f.word, f.timed_out, pop_count - p0, exp);
        end
        $display("test_enable_drop: resumed word %h", f.word);
    endtask

    task automatic test_reset_mid;
        frame_t f;
        logic [15:0] exp;
        logic [15:0] dropped;
        int p0;
        p0 = pop_count;
        push_word(16'h0000);
        push_word(16'h3C5A);
        enable = 1'b1;
        recv_frame(50, -1, 25, f);
        dropped = exp_q.pop_front();
        checks++;
        if (!f.aborted || f.tx_at_rst !== 1'b1 || f.busy_at_rst !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: aborted %0d tx %b busy %b required 1,1,0",
                     f.aborted, f.tx_at_rst, f.busy_at_rst);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        recv_frame(50, -1, -1, f);
        exp = exp_q.pop_front();
        checks++;
        if (f.word !== exp || f.done_cnt != 1 || f.par !== ^exp || f.unstable != 0) begin
            errors++;
            $display("FAIL midreset_next: word %h done %0d par %b unstable %0d required %h,1,%b,0",
                     f.word, f.done_cnt, f.par, f.unstable, exp, ^exp);
        end
        checks++;
        if (pop_count - p0 != 2) begin
            errors++;
            $display("FAIL midreset_pops: pops %0d required 2", pop_count - p0);
        end
        $display("test_reset_mid: dropped %h, then sent %h", dropped, f.word);
    endtask

    initial begin
        rst    = 1'b0;
        enable = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_empty();
        test_enable_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
